// File: rtl/stepper_driver_pro_pkg.sv
// stepper_pkg: shared types, phase table and stride helper for stepper_driver_pro
package stepper_pkg;
    typedef enum logic [1:0] {MODE_FULL = 2'd0, MODE_HALF = 2'd1, MODE_WAVE = 2'd2} mode_e;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    // Packed so that PHASE_TBL[i] is entry i; leftmost literal is index 7.
    localparam logic [7:0][3:0] PHASE_TBL = {4'b1000, 4'b1010, 4'b0010, 4'b0110,
                                             4'b0100, 4'b0101, 4'b0001, 4'b1001};
    function automatic logic [2:0] stride(mode_e m);
        return (m == MODE_HALF) ? 3'd1 : 3'd2;
    endfunction
    function automatic mode_e to_mode(logic [1:0] m);
        return (m == 2'd3) ? MODE_FULL : mode_e'(m);
    endfunction
endpackage

// File: rtl/stepper_driver_pro_if.sv
// stepper_driver_pro_if: command handshake and status bundle between motion registers and driver
interface stepper_driver_pro_if #(parameter int CNT_W = 32, parameter int DIV_W = 16);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [1:0]       cmd_mode;
    logic [DIV_W-1:0] cmd_period;
    logic             abort;
    logic [3:0]       hb_state;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] steps_left;
    logic [CNT_W-1:0] position;
    modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_mode, cmd_period, abort,
                    input cmd_ready, hb_state, busy, done, aborted, steps_left, position);
    modport slave (input cmd_valid, cmd_steps, cmd_dir, cmd_mode, cmd_period, abort,
                   output cmd_ready, hb_state, busy, done, aborted, steps_left, position);
endinterface

// File: rtl/stepper_driver_pro_step_rate_div.sv
// step_rate_div: loadable down-counter that ticks while enabled and at zero
module step_rate_div #(parameter int DIV_W = 16) (
    input  logic             clk,
    input  logic             PRESERN,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - DIV_W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!PRESERN) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign tick_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/stepper_driver_pro.sv
// stepper_driver_pro: full/half/wave bipolar stepper sequencer with handshake, abort and position.
// Define HOLD_TORQUE_EN to keep the last phase energised in IDLE instead of coasting.
module stepper_driver_pro
    import stepper_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int DIV_W = 16
) (
    input logic             clk,
    input logic             PRESERN,
    stepper_driver_pro_if.slave bus
);
    state_e           state_q, state_d;
    mode_e            mode_q, mode_d, cmd_m, sel_m;
    logic [2:0]       idx_q, idx_d, aligned, base, nxt_idx;
    logic [3:0]       hb_q, hb_d, hb_idle;
    logic             done_q, done_d, aborted_q, aborted_d, dir_q, dir_d, sel_dir;
    logic [CNT_W-1:0] left_q, left_d, pos_q, pos_d, nxt_pos, delta;
    logic [DIV_W-1:0] period_q, period_d;
    logic             run, accept, load, tick;
    assign run     = (state_q == RUN);
    assign accept  = !run && bus.cmd_valid && PRESERN;
    assign cmd_m   = to_mode(bus.cmd_mode);
    assign aligned = (cmd_m == MODE_FULL) ? {idx_q[2:1], 1'b0} :
                     (cmd_m == MODE_WAVE) ? {idx_q[2:1], 1'b1} : idx_q;
    // One stepping datapath serves both the accept cycle and subsequent RUN steps.
    assign sel_m   = run ? mode_q : cmd_m;
    assign sel_dir = run ? dir_q : bus.cmd_dir;
    assign base    = run ? idx_q : aligned;
    assign delta   = CNT_W'(stride(sel_m));
    assign nxt_idx = sel_dir ? base + stride(sel_m) : base - stride(sel_m);
    assign nxt_pos = sel_dir ? pos_q + delta : pos_q - delta;
`ifdef HOLD_TORQUE_EN
    assign hb_idle = hb_q;
`else
    assign hb_idle = 4'b0000;
`endif
    step_rate_div #(.DIV_W(DIV_W)) u_div (
        .clk        (clk),
        .PRESERN    (PRESERN),
        .load_i     (load),
        .load_val_i (run ? period_q : bus.cmd_period),
        .en_i       (run),
        .tick_o     (tick)
    );
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        hb_d      = hb_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        dir_d     = dir_q;
        left_d    = left_q;
        pos_d     = pos_q;
        period_d  = period_q;
        load      = 1'b0;
        if (!run) begin
            if (accept) begin
                dir_d     = bus.cmd_dir;
                mode_d    = cmd_m;
                period_d  = bus.cmd_period;
                aborted_d = 1'b0;
                left_d    = bus.cmd_steps;
                if (bus.cmd_steps == '0) begin
                    idx_d  = aligned;
                    done_d = 1'b1;
                end else begin
                    state_d = RUN;
                    idx_d   = nxt_idx;
                    hb_d    = PHASE_TBL[nxt_idx];
                    left_d  = bus.cmd_steps - CNT_W'(1);
                    pos_d   = nxt_pos;
                    load    = 1'b1;
                end
            end
        end else if (bus.abort) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
            hb_d      = hb_idle;
        end else if (tick) begin
            if (left_q != '0) begin
                idx_d  = nxt_idx;
                hb_d   = PHASE_TBL[nxt_idx];
                left_d = left_q - CNT_W'(1);
                pos_d  = nxt_pos;
                load   = 1'b1;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
                hb_d    = hb_idle;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!PRESERN) begin
            state_q   <= IDLE;
            mode_q    <= MODE_FULL;
            idx_q     <= '0;
            hb_q      <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            dir_q     <= 1'b0;
            left_q    <= '0;
            pos_q     <= '0;
            period_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            hb_q      <= hb_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            dir_q     <= dir_d;
            left_q    <= left_d;
            pos_q     <= pos_d;
            period_q  <= period_d;
        end
    end
    assign bus.cmd_ready  = !run && PRESERN;
    assign bus.busy       = run;
    assign bus.hb_state   = hb_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.steps_left = left_q;
    assign bus.position   = pos_q;
endmodule

// File: tb/tb_stepper_driver_pro.sv
// tb_stepper_driver_pro: directed table and corner-case sequences for stepper_driver_pro
module tb_stepper_driver_pro;
    localparam int CNT_W = 32;
    localparam int DIV_W = 16;
`ifdef HOLD_TORQUE_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    typedef struct {
        int         steps;
        bit         dir;
        logic [1:0] mode;
        int         period;
        logic [3:0] first;
        logic [3:0] last;
        int         pos;
        int         len;
    } vec_t;
    logic clk = 1'b0;
    logic PRESERN = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    vec_t v[7];
    logic [3:0] ph[4];
    logic [3:0] last;
    int   cyc;
    always #5 clk = ~clk;
    stepper_driver_pro_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();
    stepper_driver_pro #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .PRESERN (PRESERN),
        .bus     (bus)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic send(input int s, input bit d, input logic [1:0] m, input int p);
        @(negedge clk);
        bus.cmd_steps  = CNT_W'(s);
        bus.cmd_dir    = d;
        bus.cmd_mode   = m;
        bus.cmd_period = DIV_W'(p);
        bus.cmd_valid  = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask
    task automatic do_reset();
        @(negedge clk) PRESERN = 1'b0;
        @(posedge clk);
        @(negedge clk) PRESERN = 1'b1;
    endtask
    task automatic step_chk();
        @(posedge clk);
        #1;
    endtask
    initial begin
        v[0] = '{4, 1'b1, 2'd0, 2, 4'b0101, 4'b1001,  8, 12};
        v[1] = '{3, 1'b0, 2'd1, 0, 4'b1000, 4'b0010,  5,  3};
        v[2] = '{2, 1'b1, 2'd2, 1, 4'b1000, 4'b0001,  9,  4};
        v[3] = '{3, 1'b0, 2'd3, 0, 4'b1010, 4'b0101,  3,  3};
        v[4] = '{1, 1'b1, 2'd1, 3, 4'b0100, 4'b0100,  4,  4};
        v[5] = '{5, 1'b0, 2'd2, 0, 4'b0001, 4'b0001, -6,  5};
        v[6] = '{3, 1'b1, 2'd0, 0, 4'b0101, 4'b1010,  0,  3};
        ph = '{4'b0101, 4'b0110, 4'b1010, 4'b1001};
        bus.cmd_valid = 1'b0; bus.cmd_steps = '0; bus.cmd_dir = 1'b0;
        bus.cmd_mode = 2'd0; bus.cmd_period = '0; bus.abort = 1'b0;
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hb", 32'(bus.hb_state), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_aborted", 32'(bus.aborted), 32'h0);
        chk("rst_steps_left", bus.steps_left, 32'h0);
        chk("rst_position", bus.position, 32'h0);
        chk("rst_ready_low", 32'(bus.cmd_ready), 32'h0);
        @(negedge clk) PRESERN = 1'b1;
        #1 chk("rst_ready_high", 32'(bus.cmd_ready), 32'h1);
        // Full forward: each phase held exactly period+1 = 3 cycles
        send(4, 1'b1, 2'd0, 2);
        for (int c = 0; c < 12; c++) begin
            chk("ff_phase", 32'(bus.hb_state), 32'(ph[c/3]));
            step_chk();
        end
        chk("ff_done", 32'(bus.done), 32'h1);
        chk("ff_pos", bus.position, 32'd8);
        step_chk();
        chk("ff_done_width", 32'(bus.done), 32'h0);
        // Half reverse, period 0
        do_reset();
        send(3, 1'b0, 2'd1, 0);
        chk("hr_phase0", 32'(bus.hb_state), 32'b1000);
        step_chk();
        chk("hr_phase1", 32'(bus.hb_state), 32'b1010);
        step_chk();
        chk("hr_phase2", 32'(bus.hb_state), 32'b0010);
        step_chk();
        chk("hr_done", 32'(bus.done), 32'h1);
        chk("hr_pos", bus.position, -32'sd3);
        step_chk();
        chk("hr_done_width", 32'(bus.done), 32'h0);
        // Wave after full: index 2 aligns to 3 then steps to 5, 7
        do_reset();
        send(1, 1'b1, 2'd0, 0);
        step_chk();
        chk("wv_pre_done", 32'(bus.done), 32'h1);
        send(2, 1'b1, 2'd2, 0);
        chk("wv_phase0", 32'(bus.hb_state), 32'b0010);
        step_chk();
        chk("wv_phase1", 32'(bus.hb_state), 32'b1000);
        step_chk();
        chk("wv_done", 32'(bus.done), 32'h1);
        chk("wv_pos", bus.position, 32'd6);
        // Table of back-to-back moves; index and position carry over between rows
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send(v[i].steps, v[i].dir, v[i].mode, v[i].period);
            chk("tv_first_hb", 32'(bus.hb_state), 32'(v[i].first));
            chk("tv_busy", 32'(bus.busy), 32'h1);
            chk("tv_left", bus.steps_left, 32'(v[i].steps - 1));
            last = bus.hb_state;
            cyc = 0;
            while (!bus.done && cyc < 200) begin
                step_chk();
                cyc++;
                if (!bus.done) last = bus.hb_state;
            end
            chk("tv_len", 32'(cyc), 32'(v[i].len));
            chk("tv_last_hb", 32'(last), 32'(v[i].last));
            chk("tv_pos", bus.position, 32'(v[i].pos));
            chk("tv_aborted", 32'(bus.aborted), 32'h0);
            chk("tv_idle_busy", 32'(bus.busy), 32'h0);
            chk("tv_idle_hb", 32'(bus.hb_state), HOLD ? 32'(v[i].last) : 32'h0);
            chk("tv_end_left", bus.steps_left, 32'h0);
            chk("tv_ready", 32'(bus.cmd_ready), 32'h1);
        end
        // Zero-step command: done next cycle, never busy, drive unchanged
        send(0, 1'b1, 2'd0, 3);
        chk("z_done", 32'(bus.done), 32'h1);
        chk("z_busy", 32'(bus.busy), 32'h0);
        chk("z_aborted", 32'(bus.aborted), 32'h0);
        chk("z_hb", 32'(bus.hb_state), HOLD ? 32'b1010 : 32'h0);
        step_chk();
        chk("z_done_width", 32'(bus.done), 32'h0);
        chk("z_busy2", 32'(bus.busy), 32'h0);
        // Abort sampled 20 cycles after accept; a command offered mid-run is ignored
        do_reset();
        send(100, 1'b1, 2'd0, 5);
        bus.cmd_steps = CNT_W'(7);
        bus.cmd_valid = 1'b1;
        repeat (19) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        bus.cmd_valid = 1'b0;
        step_chk();
        chk("ab_busy", 32'(bus.busy), 32'h0);
        chk("ab_done", 32'(bus.done), 32'h1);
        chk("ab_aborted", 32'(bus.aborted), 32'h1);
        chk("ab_left", bus.steps_left, 32'd96);
        chk("ab_pos", bus.position, 32'd8);
        chk("ab_hb", 32'(bus.hb_state), HOLD ? 32'b1001 : 32'h0);
        step_chk();
        chk("ab_idle_done", 32'(bus.done), 32'h0);
        chk("ab_sticky", 32'(bus.aborted), 32'h1);
        chk("ab_left_frozen", bus.steps_left, 32'd96);
        @(negedge clk) bus.abort = 1'b0;
        send(1, 1'b1, 2'd1, 0);
        chk("ab_cleared", 32'(bus.aborted), 32'h0);
        step_chk();
        chk("ab_next_done", 32'(bus.done), 32'h1);
        // Reset mid-move: everything back to reset values, no done pulse
        send(10, 1'b1, 2'd0, 1);
        repeat (5) @(posedge clk);
        @(negedge clk) PRESERN = 1'b0;
        step_chk();
        chk("mr_hb", 32'(bus.hb_state), 32'h0);
        chk("mr_pos", bus.position, 32'h0);
        chk("mr_busy", 32'(bus.busy), 32'h0);
        chk("mr_done", 32'(bus.done), 32'h0);
        chk("mr_left", bus.steps_left, 32'h0);
        chk("mr_ready", 32'(bus.cmd_ready), 32'h0);
        @(negedge clk) PRESERN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step_chk();
            chk("mr_no_done", 32'(bus.done), 32'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
